display_encoder: RTL and testbench
==================================

# display_encoder

Registered 4-bit substitution encoder with dual seven-segment decimal readout. A 4-bit input word {a,b,c,d} is latched when `ready` is asserted, mapped through a fixed 16-entry substitution table, and the resulting value (0–15) is shown in decimal on two seven-segment displays: `dse` is the left (tens) digit and `dsd` is the right (units) digit. It sits at the output end of the coding-system datapath, driving the board's two seven-segment displays directly.

## Interface
- No parameters; the substitution table and segment patterns are fixed.
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset
- a  input  1  input word bit 3 (MSB)
- b  input  1  input word bit 2
- c  input  1  input word bit 1
- d  input  1  input word bit 0 (LSB)
- ready  input  1  load strobe; the input word is sampled on a rising edge of `clk` while `ready` = 1
- dse  output  7  left display (tens digit) segments, active-low, bit0 = seg a … bit6 = seg g
- dsd  output  7  right display (units digit) segments, active-low, same bit order

## Operation
- Input word N = {a,b,c,d}, where a is the MSB.
- Substitution table, written as N→code:
  - 0→10, 1→3, 2→9, 3→0, 4→8, 5→15, 6→2, 7→13
  - 8→14, 9→12, 10→11, 11→4, 12→7, 13→1, 14→6, 15→5
- The table is a bijection on 0–15.
- code is a 4-bit unsigned value.
- tens = 1 if code ≥ 10, else 0.
- units = code − 10 if code ≥ 10, else code.
- Left display shows the tens digit: '0' or '1'. The leading zero is displayed, not blanked.
- Right display shows the units digit, 0–9.
- Segment patterns (bits 6..0 = g f e d c b a, active-low):
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
  - blank = 1111111
- State held by the block: a valid flag plus the registered `dse`/`dsd` values, or equivalently the registered code.
- While `ready` = 0, the outputs hold their last value. Changes on a–d are ignored.
- `ready` held high for several cycles reloads every cycle. The outputs track the current inputs, one cycle late.

## Timing
- `reset` = 1 at a rising edge:
  - `dse` = `dsd` = 1111111 (both blank) after that edge.
  - valid is cleared.
- `reset` has priority over `ready` when both are 1 in the same cycle. The result is blank.
- `ready` = 1 and `reset` = 0 at rising edge k:
  - a–d are sampled at edge k.
  - `dse`/`dsd` show the encoded value from edge k onward, a latency of 1 clock.
- Outputs are driven straight from registers, with no combinational path from the inputs to `dse`/`dsd`.
- A reset mid-operation blanks the displays on the next edge, regardless of the previously loaded value.
- Once `reset` is released, the displays stay blank until the first `ready` pulse.
- Power-up, before the first reset, is undefined. Benches must apply `reset` first.

## Test plan
- Reset check: assert `reset` for 1 cycle, with `ready` = 0.
  - Required: `dse` = `dsd` = 1111111.
  - Then change a–d with `ready` still 0; the outputs must stay blank.
- Exhaustive load: reset, then load each N = 0..15 with a 1-cycle `ready` pulse.
  - Required after the pulse edge: the decimal of the table value.
  - N=0 (code 10): `dse` = 1111001, `dsd` = 1000000.
  - N=3 (code 0): `dse` = 1000000, `dsd` = 1000000.
  - N=5 (code 15): `dse` = 1111001, `dsd` = 0010010.
  - N=12 (code 7): `dse` = 1000000, `dsd` = 1111000.
- Hold: load N=1, giving `dse` = 1000000 and `dsd` = 0110000. Drop `ready`, set N=7.
  - Required: the outputs remain "03" for ≥5 cycles.
- Simultaneous: `reset` = 1 and `ready` = 1 in the same cycle, with N=8.
  - Required: blank, not "14".
- Continuous: hold `ready` high while N steps through 9, 10, 11 on successive cycles.
  - Required: the outputs show 12, 11, 04, each one cycle after its input.
- Reset mid-hold: load N=13 ("01"), then pulse `reset`.
  - Required: blank on the next edge, and still blank until the next `ready` pulse.

Source files
------------

// File: rtl/display_encoder.sv
// Registered 4-bit substitution encoder driving two active-low seven-segment displays.
// The loaded word is mapped through a fixed table and shown in decimal (tens on dse, units on dsd).
module display_encoder (
   input  logic       clk,
   input  logic       reset,
   input  logic       a,
   input  logic       b,
   input  logic       c,
   input  logic       d,
   input  logic       ready,
   output logic [6:0] dse,
   output logic [6:0] dsd
);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Fixed substitution table (a bijection on 0..15)
   function automatic logic [3:0] substitute(input logic [3:0] n);
      logic [3:0] code;
      case (n)
         4'd0:    code = 4'd10;
         4'd1:    code = 4'd3;
         4'd2:    code = 4'd9;
         4'd3:    code = 4'd0;
         4'd4:    code = 4'd8;
         4'd5:    code = 4'd15;
         4'd6:    code = 4'd2;
         4'd7:    code = 4'd13;
         4'd8:    code = 4'd14;
         4'd9:    code = 4'd12;
         4'd10:   code = 4'd11;
         4'd11:   code = 4'd4;
         4'd12:   code = 4'd7;
         4'd13:   code = 4'd1;
         4'd14:   code = 4'd6;
         4'd15:   code = 4'd5;
         default: code = 4'd0;
      endcase
      return code;
   endfunction

   // Decimal digit to active-low segments, bit order g f e d c b a
   function automatic logic [6:0] seg7(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

   logic [3:0] word_s;
   logic [3:0] code_s;
   logic [3:0] tens_s;
   logic [3:0] units_s;
   logic       valid_q, valid_d;
   logic [6:0] dse_q, dse_d;
   logic [6:0] dsd_q, dsd_d;

   // Encode the current input word and choose the next display contents
   always_comb begin
      word_s  = {a, b, c, d};
      code_s  = substitute(word_s);
      tens_s  = 4'd0;
      units_s = code_s;
      valid_d = valid_q;
      dse_d   = dse_q;
      dsd_d   = dsd_q;
      if (code_s >= 4'd10) begin
         tens_s  = 4'd1;
         units_s = code_s - 4'd10;
      end else begin
         tens_s  = 4'd0;
         units_s = code_s;
      end
      if (ready) begin
         valid_d = 1'b1;
         dse_d   = seg7(tens_s);
         dsd_d   = seg7(units_s);
      end else if (!valid_q) begin
         // nothing loaded since reset: keep both displays dark
         dse_d   = SEG_BLANK;
         dsd_d   = SEG_BLANK;
      end else begin
         dse_d   = dse_q;
         dsd_d   = dsd_q;
      end
   end

   // Display registers with synchronous reset to blank
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         dse_q   <= SEG_BLANK;
         dsd_q   <= SEG_BLANK;
      end else begin
         valid_q <= valid_d;
         dse_q   <= dse_d;
         dsd_q   <= dsd_d;
      end
   end

   assign dse = dse_q;
   assign dsd = dsd_q;

endmodule

// File: tb/tb_display_encoder.sv
// Self-checking bench for display_encoder: directed test-plan cases plus random
// reset/ready/word sequences checked against a table-and-arithmetic reference model.
module tb_display_encoder;

   logic       clk;
   logic       reset;
   logic       a, b, c, d;
   logic       ready;
   logic [6:0] dse;
   logic [6:0] dsd;

   int total = 0;
   int bad   = 0;

   int         sub_tbl [16] = '{10, 3, 9, 0, 8, 15, 2, 13, 14, 12, 11, 4, 7, 1, 6, 5};
   logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
   localparam logic [13:0] BLANK2 = 14'b1111111_1111111;

   logic [13:0] model_q;

   display_encoder dut (
      .clk   (clk),
      .reset (reset),
      .a     (a),
      .b     (b),
      .c     (c),
      .d     (d),
      .ready (ready),
      .dse   (dse),
      .dsd   (dsd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {dse,dsd} for a loaded word, computed from the decimal value of its code
   function automatic logic [13:0] encode(input int n);
      int code;
      code = sub_tbl[n];
      return {seg_tbl[code / 10], seg_tbl[code % 10]};
   endfunction

   task automatic check_out(input string tag, input logic [13:0] obs, input logic [13:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got dse=%b dsd=%b want dse=%b dsd=%b",
                  tag, obs[13:7], obs[6:0], exp[13:7], exp[6:0]);
      end
   endtask

   // One clock: apply inputs, advance the model, compare just after the edge
   task automatic step(input logic r, input logic rdy, input int n, input string tag);
      logic [3:0] w;
      w = n[3:0];
      reset = r;
      ready = rdy;
      {a, b, c, d} = w;
      @(posedge clk);
      #1;
      if (r)        model_q = BLANK2;
      else if (rdy) model_q = encode(n);
      else          model_q = model_q;
      check_out(tag, {dse, dsd}, model_q);
   endtask

   initial begin
      reset = 1'b1;
      ready = 1'b0;
      {a, b, c, d} = 4'd0;
      model_q = BLANK2;

      // reset, then input changes with ready low must leave the displays blank
      step(1'b1, 1'b0, 0, "reset");
      check_out("reset_blank", {dse, dsd}, BLANK2);
      step(1'b0, 1'b0, 6, "idle_a");
      step(1'b0, 1'b0, 15, "idle_b");
      check_out("idle_blank", {dse, dsd}, BLANK2);

      // exhaustive single-pulse loads
      for (int n = 0; n < 16; n++) begin
         step(1'b0, 1'b1, n, "load");
         if (n == 0)  check_out("load_n0",  {dse, dsd}, 14'b1111001_1000000);
         if (n == 3)  check_out("load_n3",  {dse, dsd}, 14'b1000000_1000000);
         if (n == 5)  check_out("load_n5",  {dse, dsd}, 14'b1111001_0010010);
         if (n == 12) check_out("load_n12", {dse, dsd}, 14'b1000000_1111000);
         step(1'b0, 1'b0, 15 - n, "load_hold");
      end

      // hold "03" while inputs change
      step(1'b0, 1'b1, 1, "hold_load");
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 7, "hold");
         check_out("hold_03", {dse, dsd}, 14'b1000000_0110000);
      end

      // reset beats ready
      step(1'b1, 1'b1, 8, "simul");
      check_out("simul_blank", {dse, dsd}, BLANK2);

      // continuous reload
      step(1'b0, 1'b1, 9, "cont9");
      check_out("cont_12", {dse, dsd}, 14'b1111001_0100100);
      step(1'b0, 1'b1, 10, "cont10");
      check_out("cont_11", {dse, dsd}, 14'b1111001_1111001);
      step(1'b0, 1'b1, 11, "cont11");
      check_out("cont_04", {dse, dsd}, 14'b1000000_0011001);

      // reset while holding a value
      step(1'b0, 1'b1, 13, "mid_load");
      check_out("mid_01", {dse, dsd}, 14'b1000000_1111001);
      step(1'b1, 1'b0, 13, "mid_reset");
      check_out("mid_blank", {dse, dsd}, BLANK2);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, i + 2, "mid_idle");
      check_out("mid_still_blank", {dse, dsd}, BLANK2);

      // random sequences
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0),
              int'($urandom_range(0, 15)), "random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
